// File: rtl/deroller.sv
// Width-restoring gatherer: packs BEATS narrow beats of IN_SIZE elements into one
// OUT_SIZE-wide vector and flags the last vector of each OUT_DEPTH-vector row.
module deroller #(
    parameter int DATA_WIDTH = 8,
    parameter int IN_SIZE    = 2,
    parameter int OUT_SIZE   = 4,
    parameter int OUT_DEPTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in [IN_SIZE],
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out [OUT_SIZE],
    output logic                  data_out_valid,
    output logic                  data_out_last,
    input  logic                  data_out_ready
);
    localparam int BEATS = OUT_SIZE / IN_SIZE;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int VW    = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] fill_q [OUT_SIZE];
    logic [DATA_WIDTH-1:0] fill_d [OUT_SIZE];
    logic [DATA_WIDTH-1:0] out_q  [OUT_SIZE];
    logic [DATA_WIDTH-1:0] out_d  [OUT_SIZE];
    logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
    logic [VW-1:0]         vec_cnt_q, vec_cnt_d;
    logic                  out_valid_q, out_valid_d;

    logic final_beat;
    logic in_fire;
    logic out_fire;

    assign final_beat    = (beat_cnt_q == BW'(BEATS - 1));
    // Only the completing beat needs a free output register; earlier beats land in fill.
    assign data_in_ready = !(final_beat && out_valid_q && !data_out_ready);
    assign in_fire       = data_in_valid && data_in_ready;
    assign out_fire      = out_valid_q && data_out_ready;

    assign data_out       = out_q;
    assign data_out_valid = out_valid_q;
    assign data_out_last  = out_valid_q && (vec_cnt_q == VW'(OUT_DEPTH - 1));

    always_comb begin
        fill_d      = fill_q;
        out_d       = out_q;
        beat_cnt_d  = beat_cnt_q;
        vec_cnt_d   = vec_cnt_q;
        out_valid_d = out_valid_q;

        if (out_fire) begin
            out_valid_d = 1'b0;
            vec_cnt_d   = (vec_cnt_q == VW'(OUT_DEPTH - 1)) ? '0 : vec_cnt_q + 1'b1;
        end

        if (in_fire) begin
            for (int k = 0; k < BEATS; k++) begin
                if (beat_cnt_q == BW'(k)) begin
                    for (int j = 0; j < IN_SIZE; j++) begin
                        fill_d[k*IN_SIZE + j] = data_in[j];
                    end
                end
            end
            if (final_beat) begin
                // Lower lanes come from earlier beats; the top lanes bypass fill.
                for (int i = 0; i < OUT_SIZE - IN_SIZE; i++) begin
                    out_d[i] = fill_q[i];
                end
                for (int j = 0; j < IN_SIZE; j++) begin
                    out_d[OUT_SIZE - IN_SIZE + j] = data_in[j];
                end
                out_valid_d = 1'b1;
                beat_cnt_d  = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < OUT_SIZE; i++) begin
                fill_q[i] <= '0;
                out_q[i]  <= '0;
            end
            beat_cnt_q  <= '0;
            vec_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fill_q      <= fill_d;
            out_q       <= out_d;
            beat_cnt_q  <= beat_cnt_d;
            vec_cnt_q   <= vec_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_deroller.sv
// Bench for deroller: directed steps then random traffic, checked every cycle against
// an element-queue model of the gathering and row-last rules.
module tb_deroller;
  localparam int DW  = 8;
  localparam int INS = 2;
  localparam int OUTS = 4;
  localparam int DEPTH = 3;
  localparam int VW = OUTS * DW;

  // valid/ready: a beat or vector moves on a rising edge where both valid and ready are high.
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] din [INS];
  logic din_valid = 1'b0;
  logic din_ready;
  logic [DW-1:0] dout [OUTS];
  logic dout_valid;
  logic dout_last;
  logic dout_ready = 1'b1;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] elem_q [$];
  logic [VW:0] exp_q [$];
  int vec_num = 0;
  int outs = 0;
  logic [15:0] last_log = '0;
  logic fire_in;
  logic fire_out;

  deroller #(.DATA_WIDTH(DW), .IN_SIZE(INS), .OUT_SIZE(OUTS), .OUT_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .data_in(din),
    .data_in_valid(din_valid),
    .data_in_ready(din_ready),
    .data_out(dout),
    .data_out_valid(dout_valid),
    .data_out_last(dout_last),
    .data_out_ready(dout_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] pack(input logic [DW-1:0] v [OUTS]);
    logic [VW-1:0] r;
    for (int i = 0; i < OUTS; i++) r[i*DW +: DW] = v[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: check outputs at negedge, advance the model by the handshakes seen.
  task automatic cycle();
    logic [VW:0] v;
    @(negedge clk);
    fire_in = 1'b0;
    fire_out = 1'b0;
    if (rst) begin
      elem_q.delete();
      exp_q.delete();
      vec_num = 0;
    end else begin
      chk("valid", dout_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        v = exp_q[0];
        chk("data", pack(dout), v[VW-1:0]);
        chk("last", dout_last, v[VW]);
      end else begin
        chk("last_idle", dout_last, 0);
      end
      chk("ready", din_ready, !(elem_q.size() == OUTS - INS && exp_q.size() > 0 && !dout_ready));
      fire_out = dout_valid && dout_ready;
      fire_in = din_valid && din_ready;
      if (fire_out) begin
        last_log = {last_log[14:0], dout_last};
        outs++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (fire_in) begin
        for (int j = 0; j < INS; j++) elem_q.push_back(din[j]);
        if (elem_q.size() == OUTS) begin
          for (int i = 0; i < OUTS; i++) v[i*DW +: DW] = elem_q[i];
          v[VW] = ((vec_num % DEPTH) == DEPTH - 1);
          vec_num++;
          exp_q.push_back(v);
          elem_q.delete();
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int n;
    din[0] = a;
    din[1] = b;
    din_valid = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!fire_in && n < 50);
    chk("send_accepted", fire_in, 1);
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int o0;
    int stalls;
    din[0] = '0;
    din[1] = '0;
    @(posedge clk);
    #1;

    // Reset
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("rst_valid", dout_valid, 0);
    chk("rst_last", dout_last, 0);
    chk("rst_data", pack(dout), 0);
    chk("rst_ready", din_ready, 1);

    // Basic gather
    dout_ready = 1'b1;
    send_beat(8'd1, 8'd2);
    chk("basic_not_yet", dout_valid, 0);
    send_beat(8'd3, 8'd4);
    chk("basic_valid", dout_valid, 1);
    chk("basic_data", pack(dout), 32'h04030201);
    chk("basic_last", dout_last, 0);
    cycle();
    chk("basic_one_cycle", dout_valid, 0);
    idle(2);

    // Backpressure
    rst = 1'b1; idle(1); rst = 1'b0;
    o0 = outs;
    dout_ready = 1'b0;
    send_beat(8'd1, 8'd2);
    send_beat(8'd3, 8'd4);
    send_beat(8'd5, 8'd6);
    din[0] = 8'd7; din[1] = 8'd8; din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_stall", fire_in, 0);
      chk("bp_hold", pack(dout), 32'h04030201);
    end
    dout_ready = 1'b1;
    cycle();
    chk("bp_final_accepted", fire_in, 1);
    chk("bp_second", pack(dout), 32'h08070605);
    din_valid = 1'b0;
    idle(3);
    chk("bp_count", outs - o0, 2);

    // Last flag over six vectors
    rst = 1'b1; idle(1); rst = 1'b0;
    for (int v = 0; v < 6; v++) begin
      send_beat(DW'(4*v+1), DW'(4*v+2));
      send_beat(DW'(4*v+3), DW'(4*v+4));
    end
    idle(2);
    chk("last_pattern", last_log[5:0], 6'b001001);

    // Full-rate streaming
    o0 = outs;
    stalls = 0;
    din_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din[0] = DW'($urandom);
      din[1] = DW'($urandom);
      cycle();
      if (!fire_in) stalls++;
    end
    din_valid = 1'b0;
    idle(2);
    chk("fr_stalls", stalls, 0);
    chk("fr_count", outs - o0, 10);

    // Reset mid-vector
    send_beat(8'd9, 8'd9);
    rst = 1'b1; idle(1); rst = 1'b0;
    send_beat(8'd9, 8'd10);
    send_beat(8'd11, 8'd12);
    chk("mid_rst_data", pack(dout), 32'h0c0b0a09);
    chk("mid_rst_last", dout_last, 0);
    for (int v = 0; v < 2; v++) begin
      send_beat(DW'($urandom), DW'($urandom));
      send_beat(DW'($urandom), DW'($urandom));
    end
    idle(2);
    chk("mid_rst_pattern", last_log[2:0], 3'b001);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      din_valid = ($urandom_range(0, 3) != 0);
      dout_ready = ($urandom_range(0, 2) != 0);
      din[0] = DW'($urandom);
      din[1] = DW'($urandom);
      cycle();
    end
    din_valid = 1'b0;
    dout_ready = 1'b1;
    idle(4);
    chk("final_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
